regfile_write_queue: RTL and testbench
======================================

Name: regfile_write_queue

Overview:
- Write-back buffer directly upstream of the 16 x 32-bit register file; accepts write requests (register index, data) from the execute/write-back path through a valid/ready handshake.
- Holds them in a DEPTH-entry FIFO and drains one per cycle into the register file's write interface (load enable, register select, write data).
- Provides two read-bypass ports so operand reads see pending (not yet drained) writes, keeping the register file's two mux read ports coherent.

Parameters:
DATA_W, 32, width of register data
ADDR_W, 4, register index width (2**ADDR_W = 16 registers)
DEPTH, 4, FIFO entries (power of two, >= 2)

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
wr_valid  in  1  write request present
wr_ready  out  1  queue can accept (count < DEPTH)
wr_addr  in  ADDR_W  destination register index
wr_data  in  DATA_W  data to write
drain_en  in  1  permit draining this cycle (0 = hold head)
rf_ld  out  1  register-file load enable (to decoder ld)
rf_sel  out  ADDR_W  register-file destination select (to decoder D)
rf_data  out  DATA_W  register-file write data
rd_addr_a  in  ADDR_W  read port A index (same as mux A select)
rd_addr_b  in  ADDR_W  read port B index
rf_q_a  in  DATA_W  register-file mux A output
rf_q_b  in  DATA_W  register-file mux B output
rd_data_a  out  DATA_W  coherent read data A
rd_data_b  out  DATA_W  coherent read data B
hit_a  out  1  rd_data_a came from bypass
hit_b  out  1  rd_data_b came from bypass
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=0, count=0, all entry-valid bits cleared, rf_ld=0, rf_sel=0, rf_data=0. Pending writes are discarded; asserting reset mid-drain drops rf_ld immediately.
- wr_ready = (count != DEPTH), combinational from registered count. There is no pass-through when full.
- push = wr_valid & wr_ready. On the edge, store {wr_addr, wr_data} at wr_ptr, then increment wr_ptr (wraps mod DEPTH).
- pop = drain_en & (count != 0), evaluated on the pre-edge count. A push into an empty queue cannot pop on the same edge. Minimum latency: accepted at edge k, rf_ld high after edge k+1.
- On a pop edge: rf_ld<=1, rf_sel<=head.addr, rf_data<=head.data, then increment rd_ptr. On a non-pop edge: rf_ld<=0, while rf_sel and rf_data hold their previous values.
- rf_ld is high for exactly one cycle per drained entry. Back-to-back drains give consecutive single-cycle pulses with the new sel/data each cycle.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. Simultaneous push and pop is legal at any 0 < count < DEPTH, including count=DEPTH-1.
- Pointers are ADDR log2(DEPTH) bits; full/empty are decided by count alone.
- Bypass, per port, is combinational. Sources in priority order:
  - youngest valid queue entry with addr == rd_addr;
  - older entries;
  - the rf output stage (rf_ld=1 and rf_sel == rd_addr), since that write is landing this cycle;
  - otherwise rf_q.
- hit=1 for any bypass source. The request being pushed in the same cycle is NOT visible to bypass until after its edge.
- Duplicate addresses in the queue are allowed and drain in FIFO order, so the last write wins in the register file.
- drain_en=0 with a full queue: wr_ready=0 and the state is frozen; wr_valid is ignored.

Decomposition:
- Shared package rf_pkg holds:
  - RF_ADDR_W=4, RF_DATA_W=32, RF_NUM_REGS=16;
  - typedef rf_wr_req_t {addr, data};
  - used also by the register-file wrapper and the write-back stage.
- One sub-module, regfile_wq_match: combinational youngest-match search over the entries plus the rf stage, returning {hit, data}. It is instantiated once per read port.

Test Plan:
- Reset then idle -> rf_ld=0, count=0, wr_ready=1, rd_data_a=rf_q_a, hit_a=0.
- Push (addr 3, 0xDEADBEEF) at edge 0 with drain_en=1 -> after edge 1: rf_ld=1, rf_sel=3, rf_data=0xDEADBEEF; after edge 2: rf_ld=0, count=0.
- drain_en=0, push addr 1..4 with data 0x11..0x44 -> count=4, wr_ready=0, 5th request not accepted. Then drain_en=1 -> four consecutive rf_ld pulses with sel 1,2,3,4.
- drain_en=0, push (5, 0xA) then (5, 0xB); rd_addr_a=5 -> rd_data_a=0xB, hit_a=1; rd_addr_b=6 -> rd_data_b=rf_q_b, hit_b=0.
- count=2 with push and pop on the same edge -> count stays 2, FIFO order preserved; continue across pointer wrap (8+ pushes) with data intact.
- reset asserted asynchronously while rf_ld=1 and count=3 -> rf_ld=0 and count=0 immediately; no further rf_ld pulses after release.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared register-file widths and write-request type
package rf_pkg;
    localparam int RF_ADDR_W   = 4;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REGS = 16;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wr_req_t;
endpackage

// File: rtl/regfile_write_queue_if.sv
// rtl/regfile_write_queue_if.sv - write-request handshake into the write queue
interface regfile_write_queue_if
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W
);
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/regfile_wq_match.sv
// rtl/regfile_wq_match.sv - youngest-match bypass search over queue entries and rf stage
module regfile_wq_match
    import rf_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DATA_W = RF_DATA_W,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] entry_addr [DEPTH],
    input  logic [DATA_W-1:0] entry_data [DEPTH],
    input  logic [DEPTH-1:0]  entry_valid,
    input  logic [PTR_W-1:0]  head,
    input  logic              stage_ld,
    input  logic [ADDR_W-1:0] stage_sel,
    input  logic [DATA_W-1:0] stage_data,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rf_q,
    output logic              hit,
    output logic [DATA_W-1:0] data
);
    logic [PTR_W-1:0] idx;

    // Walk oldest to youngest so a later match overrides: the youngest write wins.
    always_comb begin
        hit  = 1'b0;
        data = rf_q;
        idx  = '0;
        if (stage_ld && (stage_sel == rd_addr)) begin
            hit  = 1'b1;
            data = stage_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if (entry_valid[idx] && (entry_addr[idx] == rd_addr)) begin
                hit  = 1'b1;
                data = entry_data[idx];
            end
        end
    end
endmodule

// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - write-back FIFO draining into the register file with read bypass
module regfile_write_queue
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_write_queue_if.slave  wr,
    input  logic                  drain_en,
    output logic                  rf_ld,
    output logic [ADDR_W-1:0]     rf_sel,
    output logic [DATA_W-1:0]     rf_data,
    input  logic [ADDR_W-1:0]     rd_addr_a,
    input  logic [ADDR_W-1:0]     rd_addr_b,
    input  logic [DATA_W-1:0]     rf_q_a,
    input  logic [DATA_W-1:0]     rf_q_b,
    output logic [DATA_W-1:0]     rd_data_a,
    output logic [DATA_W-1:0]     rd_data_b,
    output logic                  hit_a,
    output logic                  hit_b,
    output logic [CNT_W-1:0]      count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [DEPTH-1:0]  ent_valid;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign wr.wr_ready = (count != CNT_W'(DEPTH));
    assign push        = wr.wr_valid & wr.wr_ready;
    assign pop         = drain_en & (count != '0);

    // Payload storage needs no reset; ent_valid gates every use of it.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[wr_ptr] <= wr.wr_addr;
            ent_data[wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            ent_valid <= '0;
            rf_ld     <= 1'b0;
            rf_sel    <= '0;
            rf_data   <= '0;
        end else begin
            if (push) begin
                ent_valid[wr_ptr] <= 1'b1;
                wr_ptr            <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                ent_valid[rd_ptr] <= 1'b0;
                rd_ptr            <= rd_ptr + PTR_W'(1);
                rf_ld             <= 1'b1;
                rf_sel            <= ent_addr[rd_ptr];
                rf_data           <= ent_data[rd_ptr];
            end else begin
                rf_ld <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    regfile_wq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_a (
        .entry_addr  (ent_addr),
        .entry_data  (ent_data),
        .entry_valid (ent_valid),
        .head        (rd_ptr),
        .stage_ld    (rf_ld),
        .stage_sel   (rf_sel),
        .stage_data  (rf_data),
        .rd_addr     (rd_addr_a),
        .rf_q        (rf_q_a),
        .hit         (hit_a),
        .data        (rd_data_a)
    );

    regfile_wq_match #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_match_b (
        .entry_addr  (ent_addr),
        .entry_data  (ent_data),
        .entry_valid (ent_valid),
        .head        (rd_ptr),
        .stage_ld    (rf_ld),
        .stage_sel   (rf_sel),
        .stage_data  (rf_data),
        .rd_addr     (rd_addr_b),
        .rf_q        (rf_q_b),
        .hit         (hit_b),
        .data        (rd_data_b)
    );
endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - scoreboard bench for regfile_write_queue
module tb_regfile_write_queue;
    import rf_pkg::*;

    logic        clk;
    logic        reset;
    logic        drain_en;
    logic        rf_ld;
    logic [3:0]  rf_sel;
    logic [31:0] rf_data;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic [31:0] rf_q_a, rf_q_b;
    logic [31:0] rd_data_a, rd_data_b;
    logic        hit_a, hit_b;
    logic [2:0]  count;

    int vectors;
    int miscompares;
    rf_wr_req_t sb[$];

    regfile_write_queue_if #(.ADDR_W(4), .DATA_W(32)) wr_if ();

    regfile_write_queue #(.DATA_W(32), .ADDR_W(4), .DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .wr        (wr_if.slave),
        .drain_en  (drain_en),
        .rf_ld     (rf_ld),
        .rf_sel    (rf_sel),
        .rf_data   (rf_data),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rf_q_a    (rf_q_a),
        .rf_q_b    (rf_q_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .hit_a     (hit_a),
        .hit_b     (hit_b),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [31:0] d, input bit acc);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr  = a;
        wr_if.wr_data  = d;
        if (acc) sb.push_back('{addr: a, data: d});
        step();
        wr_if.wr_valid = 1'b0;
    endtask

    // Monitor: every rf_ld pulse must match the next expected drained write.
    always @(negedge clk) begin
        if (reset && rf_ld) begin
            if (sb.size() == 0) begin
                chk("unexpected_rf_ld", 32'(rf_sel), 32'hFFFF_FFFF);
            end else begin
                rf_wr_req_t e;
                e = sb.pop_front();
                chk("drain_sel", 32'(rf_sel), 32'(e.addr));
                chk("drain_data", rf_data, e.data);
            end
        end
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        reset = 1'b0;
        drain_en = 1'b0;
        wr_if.wr_valid = 1'b0;
        wr_if.wr_addr = '0;
        wr_if.wr_data = '0;
        rd_addr_a = 4'd0;
        rd_addr_b = 4'd0;
        rf_q_a = 32'h1234_5678;
        rf_q_b = 32'h9ABC_DEF0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_rf_ld", 32'(rf_ld), 32'd0);
        chk("reset_count", 32'(count), 32'd0);
        chk("reset_wr_ready", 32'(wr_if.wr_ready), 32'd1);
        chk("reset_rd_data_a", rd_data_a, 32'h1234_5678);
        chk("reset_hit_a", 32'(hit_a), 32'd0);

        // single write, minimum latency
        drain_en = 1'b1;
        push(4'd3, 32'hDEAD_BEEF, 1'b1);
        chk("lat_count1", 32'(count), 32'd1);
        chk("lat_ld_k", 32'(rf_ld), 32'd0);
        step();
        chk("lat_ld_k1", 32'(rf_ld), 32'd1);
        chk("lat_count0", 32'(count), 32'd0);
        step();
        chk("lat_ld_k2", 32'(rf_ld), 32'd0);

        // fill, reject when full, then back-to-back drain
        drain_en = 1'b0;
        push(4'd1, 32'h11, 1'b1);
        push(4'd2, 32'h22, 1'b1);
        push(4'd3, 32'h33, 1'b1);
        push(4'd4, 32'h44, 1'b1);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(wr_if.wr_ready), 32'd0);
        push(4'd5, 32'h55, 1'b0);
        chk("full_hold", 32'(count), 32'd4);
        drain_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("b2b_ld", 32'(rf_ld), 32'd1);
        end
        step();
        chk("b2b_end_ld", 32'(rf_ld), 32'd0);
        chk("b2b_end_count", 32'(count), 32'd0);

        // bypass: youngest wins, same-cycle push invisible, rf stage visible
        drain_en = 1'b0;
        push(4'd5, 32'hA, 1'b1);
        wr_if.wr_valid = 1'b1;
        wr_if.wr_addr = 4'd5;
        wr_if.wr_data = 32'hB;
        sb.push_back('{addr: 4'd5, data: 32'hB});
        rd_addr_a = 4'd5;
        rd_addr_b = 4'd6;
        #1;
        chk("byp_same_cycle", rd_data_a, 32'hA);
        step();
        wr_if.wr_valid = 1'b0;
        #1;
        chk("byp_youngest", rd_data_a, 32'hB);
        chk("byp_hit_a", 32'(hit_a), 32'd1);
        chk("byp_miss_b", rd_data_b, 32'h9ABC_DEF0);
        chk("byp_hit_b", 32'(hit_b), 32'd0);
        drain_en = 1'b1;
        step();
        chk("byp_queue_over_stage", rd_data_a, 32'hB);
        step();
        chk("byp_stage", rd_data_a, 32'hB);
        chk("byp_stage_hit", 32'(hit_a), 32'd1);
        step();
        chk("byp_none", rd_data_a, 32'h1234_5678);
        chk("byp_none_hit", 32'(hit_a), 32'd0);

        // simultaneous push/pop at count=2 across pointer wrap
        drain_en = 1'b0;
        push(4'd7, 32'h100, 1'b1);
        push(4'd8, 32'h101, 1'b1);
        drain_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push(4'(i), 32'h2000 + 32'(i), 1'b1);
            chk("pp_count2", 32'(count), 32'd2);
        end
        step();
        step();
        chk("pp_empty", 32'(count), 32'd0);
        step();

        // count=DEPTH-1 push/pop, then async reset mid-drain
        drain_en = 1'b0;
        push(4'd1, 32'hA1, 1'b1);
        push(4'd2, 32'hA2, 1'b1);
        push(4'd3, 32'hA3, 1'b1);
        drain_en = 1'b1;
        push(4'd4, 32'hA4, 1'b1);
        chk("pp_count3", 32'(count), 32'd3);
        chk("pp_ld3", 32'(rf_ld), 32'd1);
        reset = 1'b0;
        sb.delete();
        #1;
        chk("arst_ld", 32'(rf_ld), 32'd0);
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_ready", 32'(wr_if.wr_ready), 32'd1);
        #2 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_ld", 32'(rf_ld), 32'd0);
        end
        chk("post_rst_count", 32'(count), 32'd0);
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
